// File: rtl/mips_muldiv_alu.sv
// mips_muldiv_alu: EX-stage ALU. Single-cycle logic and arithmetic ops finish
// in the cycle they are started. mult/multu/div/divu run on an iterative
// shift-add / restoring-divide datapath and write the HI/LO registers.
module mips_muldiv_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_MFHI = 4'b0100;
    localparam logic [3:0] OP_MFLO = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;

    localparam int              CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES     = '1;
    localparam int              MSB       = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state, state_next;

    // Iterative datapath registers
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] saved_a;
    logic [CW-1:0]    count;
    logic             div_r;
    logic             neg_res;
    logic             neg_rem;
    logic             dz_r;
    logic             ovf_r;

    // Decode of the incoming operation
    logic             is_muldiv;
    logic             op_signed;
    logic             op_div;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign is_muldiv = alu_op[3] && !alu_op[2];
    assign op_signed = !alu_op[0];
    assign op_div    = alu_op[1];
    assign neg_a     = op_signed && a[MSB];
    assign neg_b     = op_signed && b[MSB];
    assign mag_a     = neg_a ? -a : a;
    assign mag_b     = neg_b ? -b : b;

    // Single-cycle ALU results
    logic [WIDTH-1:0] sum_ab;
    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign sum_ab  = a + b;
    assign diff_ab = a - b;

    // One iteration of shift-add multiply and restoring divide
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;

    assign mul_addend = acc_lo[0] ? m_reg : '0;
    assign mul_sum    = {1'b0, acc_hi} + {1'b0, mul_addend};
    assign div_shift  = {acc_hi, acc_lo[MSB]};
    assign div_ge     = div_shift >= {1'b0, m_reg};
    assign div_sub    = div_shift[WIDTH-1:0] - m_reg;

    // Sign correction applied when the iterations are finished
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign q_fix    = neg_res ? -acc_lo : acc_lo;
    assign r_fix    = neg_rem ? -acc_hi : acc_hi;

    assign busy = (state != IDLE);
    assign zero = (result == '0);

    // Select the single-cycle result and its signed-overflow flag
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_res = sum_ab;
                alu_ovf = (a[MSB] == b[MSB]) && (sum_ab[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff_ab;
                alu_ovf = (a[MSB] != b[MSB]) && (diff_ab[MSB] != a[MSB]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // Pick the final HI/LO pair, with the divide-by-zero override
    always_comb begin
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (div_r) begin
            if (dz_r) begin
                fix_hi = saved_a;
                fix_lo = ONES;
            end else begin
                fix_hi = r_fix;
                fix_lo = q_fix;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: starts are only accepted while idle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && is_muldiv) state_next = RUN;
            RUN:  if (count == LAST_ITER) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, result and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result      <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            m_reg       <= '0;
            saved_a     <= '0;
            count       <= '0;
            div_r       <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dz_r        <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_muldiv) begin
                            acc_hi  <= '0;
                            acc_lo  <= op_div ? mag_a : mag_b;
                            m_reg   <= op_div ? mag_b : mag_a;
                            saved_a <= a;
                            count   <= '0;
                            div_r   <= op_div;
                            neg_res <= neg_a ^ neg_b;
                            neg_rem <= neg_a;
                            dz_r    <= op_div && (b == '0);
                            ovf_r   <= op_div && op_signed && (a == MIN_VAL) && (b == ONES);
                        end else begin
                            result      <= alu_res;
                            overflow    <= alu_ovf;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (div_r) begin
                        acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    result      <= fix_lo;
                    overflow    <= ovf_r;
                    div_by_zero <= dz_r;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
